// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single byte-addressed memory.
//   Port 0 is instruction fetch, port 1 is load/store. One transaction runs
//   at a time through IDLE -> ACCESS -> RESP, so at most one transaction
//   completes every three cycles.
//
// Configuration macro:
//   MEM_ARBITER_RR_EN  defined   : simultaneous requests are granted round-robin
//                      undefined : simultaneous requests go to port 1 (fixed priority)
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   req_valid_i[1:0]   per-port request valid
//   req_ready_o[1:0]   per-port grant (IDLE only, combinational from req_valid_i)
//   req_we_i[1:0]      per-port write enable
//   req_addr_i         per-port byte address, port n at [n*AWIDTH +: AWIDTH]
//   req_wdata_i        per-port write data,   port n at [n*DWIDTH +: DWIDTH]
//   rsp_valid_o[1:0]   one-cycle response pulse to the accepted port
//   rsp_err_o          out-of-range flag, valid with rsp_valid_o
//   rsp_rdata_o        read data, valid with rsp_valid_o
//   mem_en_o, mem_wen_o, mem_addr_o, mem_wdata_o   memory access strobes
//   mem_rdata_i        combinational read data from the memory
module mem_arbiter #(
  parameter int unsigned  MEMSIZE   = 'h400,
  parameter int unsigned  DWIDTH    = 32,
  localparam int unsigned BYTESPERW = DWIDTH / 8,
  localparam int unsigned AWIDTH    = $clog2(MEMSIZE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_we_i,
  input  logic [2*AWIDTH-1:0]   req_addr_i,
  input  logic [2*DWIDTH-1:0]   req_wdata_i,
  output logic [1:0]            rsp_valid_o,
  output logic                  rsp_err_o,
  output logic [DWIDTH-1:0]     rsp_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_wen_o,
  output logic [AWIDTH-1:0]     mem_addr_o,
  output logic [DWIDTH-1:0]     mem_wdata_o,
  input  logic [DWIDTH-1:0]     mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic                last_grant_q, last_grant_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [1:0]          grant_c;
  logic                both_pick_c;
  logic                accept_c;
  logic                grant_id_c;
  logic [31:0]         last_byte_c;
  logic                oor_c;

  // Winner when both ports request in the same IDLE cycle (1 = port 1).
`ifdef MEM_ARBITER_RR_EN
  assign both_pick_c = ~last_grant_q;
`else
  logic unused_last_grant;
  assign both_pick_c       = 1'b1;
  assign unused_last_grant = last_grant_q;
`endif

  // Grant: only in IDLE, only out of reset, only to a requesting port.
  always_comb begin
    grant_c = 2'b00;
    if (reset_n && (state_q == IDLE)) begin
      case (req_valid_i)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = both_pick_c ? 2'b10 : 2'b01;
        default: grant_c = 2'b00;
      endcase
    end
  end

  assign accept_c   = |grant_c;
  assign grant_id_c = grant_c[1];

  // Last byte touched by the latched access; beyond the memory means error.
  assign last_byte_c = 32'(addr_q) + 32'(BYTESPERW - 1);
  assign oor_c       = (last_byte_c > 32'(MEMSIZE - 1));

  // State register and transaction latches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= 1'b1;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Next-state and latch updates.
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d      = ACCESS;
          port_d       = grant_id_c;
          last_grant_d = grant_id_c;
          we_d         = grant_id_c ? req_we_i[1] : req_we_i[0];
          addr_d       = grant_id_c ? req_addr_i[AWIDTH +: AWIDTH]
                                    : req_addr_i[0 +: AWIDTH];
          wdata_d      = grant_id_c ? req_wdata_i[DWIDTH +: DWIDTH]
                                    : req_wdata_i[0 +: DWIDTH];
        end
      end
      ACCESS: begin
        state_d = RESP;
        err_d   = oor_c;
        rdata_d = (oor_c || we_q) ? '0 : mem_rdata_i;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o = grant_c;
  assign rsp_valid_o = (state_q == RESP) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_err_o   = err_q;
  assign rsp_rdata_o = rdata_q;

  // Memory strobes live only in ACCESS; an out-of-range access never enables.
  assign mem_en_o    = (state_q == ACCESS) && !oor_c;
  assign mem_wen_o   = (state_q == ACCESS) && !oor_c && we_q;
  assign mem_addr_o  = (state_q == ACCESS) ? addr_q  : '0;
  assign mem_wdata_o = (state_q == ACCESS) ? wdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned MEMSIZE = 'h400;
  localparam int unsigned DWIDTH  = 32;
  localparam int unsigned AWIDTH  = 10;

  logic                clk;
  logic                reset_n;
  logic [1:0]          req_valid_i;
  logic [1:0]          req_ready_o;
  logic [1:0]          req_we_i;
  logic [2*AWIDTH-1:0] req_addr_i;
  logic [2*DWIDTH-1:0] req_wdata_i;
  logic [1:0]          rsp_valid_o;
  logic                rsp_err_o;
  logic [DWIDTH-1:0]   rsp_rdata_o;
  logic                mem_en_o;
  logic                mem_wen_o;
  logic [AWIDTH-1:0]   mem_addr_o;
  logic [DWIDTH-1:0]   mem_wdata_o;
  logic [DWIDTH-1:0]   mem_rdata_i;

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter #(.MEMSIZE(MEMSIZE), .DWIDTH(DWIDTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_rdata_o (rsp_rdata_o),
    .mem_en_o    (mem_en_o),
    .mem_wen_o   (mem_wen_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte memory: combinational read, write on the clock edge.
  logic [7:0] mem [0:MEMSIZE-1];

  initial begin
    for (int i = 0; i < int'(MEMSIZE); i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (mem_en_o && mem_wen_o) begin
      for (int b = 0; b < 4; b++)
        mem[int'(mem_addr_o) + b] <= mem_wdata_o[8*b +: 8];
    end
  end

  always_comb begin
    mem_rdata_i = '0;
    if (int'(mem_addr_o) <= int'(MEMSIZE) - 4)
      mem_rdata_i = {mem[int'(mem_addr_o) + 3], mem[int'(mem_addr_o) + 2],
                     mem[int'(mem_addr_o) + 1], mem[int'(mem_addr_o)]};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on a single port, checking every phase.
  task automatic txn(input string tag, input int p, input logic we,
                     input logic [AWIDTH-1:0] addr, input logic [DWIDTH-1:0] wd,
                     input logic exp_err, input logic [DWIDTH-1:0] exp_rdata);
    logic [1:0] onehot;
    onehot = (p == 1) ? 2'b10 : 2'b01;
    req_valid_i                  = onehot;
    req_we_i                     = we ? onehot : 2'b00;
    req_addr_i[p*AWIDTH +: AWIDTH] = addr;
    req_wdata_i[p*DWIDTH +: DWIDTH] = wd;
    #1;
    chk({tag, " idle ready"}, 64'(req_ready_o), 64'(onehot));
    step();
    // ACCESS: scramble requester inputs; latched values must be used.
    req_valid_i = 2'b00;
    req_we_i    = ~req_we_i;
    req_addr_i  = '1;
    req_wdata_i = '1;
    #1;
    chk({tag, " access ready"},  64'(req_ready_o), 64'd0);
    chk({tag, " access en"},     64'(mem_en_o),    64'(!exp_err));
    chk({tag, " access wen"},    64'(mem_wen_o),   64'(we && !exp_err));
    chk({tag, " access addr"},   64'(mem_addr_o),  64'(addr));
    chk({tag, " access wdata"},  64'(mem_wdata_o), 64'(wd));
    chk({tag, " access rvalid"}, 64'(rsp_valid_o), 64'd0);
    step();
    chk({tag, " resp rvalid"}, 64'(rsp_valid_o), 64'(onehot));
    chk({tag, " resp err"},    64'(rsp_err_o),   64'(exp_err));
    chk({tag, " resp rdata"},  64'(rsp_rdata_o), 64'(exp_rdata));
    chk({tag, " resp ready"},  64'(req_ready_o), 64'd0);
    chk({tag, " resp en"},     64'(mem_en_o),    64'd0);
    step();
    chk({tag, " idle rvalid"}, 64'(rsp_valid_o), 64'd0);
    chk({tag, " hold rdata"},  64'(rsp_rdata_o), 64'(exp_rdata));
    chk({tag, " hold err"},    64'(rsp_err_o),   64'(exp_err));
    req_we_i    = 2'b00;
    req_addr_i  = '0;
    req_wdata_i = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ready"},  64'(req_ready_o), 64'd0);
    chk({tag, " rvalid"}, 64'(rsp_valid_o), 64'd0);
    chk({tag, " err"},    64'(rsp_err_o),   64'd0);
    chk({tag, " rdata"},  64'(rsp_rdata_o), 64'd0);
    chk({tag, " en"},     64'(mem_en_o),    64'd0);
    chk({tag, " wen"},    64'(mem_wen_o),   64'd0);
    chk({tag, " addr"},   64'(mem_addr_o),  64'd0);
    chk({tag, " wdata"},  64'(mem_wdata_o), 64'd0);
  endtask

  logic [1:0]        exp_g;
  logic [DWIDTH-1:0] exp_d;

  initial begin
    reset_n     = 1'b0;
    req_valid_i = 2'b11;
    req_we_i    = 2'b00;
    req_addr_i  = '0;
    req_wdata_i = '0;
    step();
    step();
    chk_all_zero("reset");
    req_valid_i = 2'b00;
    reset_n     = 1'b1;
    step();

    // Write then read back on port 0.
    txn("wr010", 0, 1'b1, 10'h010, 32'hDEADBEEF, 1'b0, 32'h0);
    txn("rd010", 0, 1'b0, 10'h010, 32'h0,        1'b0, 32'hDEADBEEF);

    // Range boundary on port 1.
    txn("rd3FD", 1, 1'b0, 10'h3FD, 32'h0,        1'b1, 32'h0);
    txn("wr3FC", 1, 1'b1, 10'h3FC, 32'hCAFEF00D, 1'b0, 32'h0);
    txn("rd3FC", 1, 1'b0, 10'h3FC, 32'h0,        1'b0, 32'hCAFEF00D);

    // Preload the arbitration targets.
    txn("wr000", 0, 1'b1, 10'h000, 32'h11111111, 1'b0, 32'h0);
    txn("wr004", 1, 1'b1, 10'h004, 32'h22222222, 1'b0, 32'h0);

    // Both ports hold requests for 12 cycles after a fresh reset.
    reset_n = 1'b0;
    step();
    req_valid_i = 2'b11;
    req_we_i    = 2'b00;
    req_addr_i  = {10'h004, 10'h000};
    reset_n     = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_RR_EN
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b10;
`endif
      exp_d = (exp_g == 2'b01) ? 32'h11111111 : 32'h22222222;
      #1;
      chk("arb grant", 64'(req_ready_o), 64'(exp_g));
      step();
      chk("arb access ready", 64'(req_ready_o), 64'd0);
      step();
      chk("arb rvalid", 64'(rsp_valid_o), 64'(exp_g));
      chk("arb rdata",  64'(rsp_rdata_o), 64'(exp_d));
      step();
    end
    req_valid_i = 2'b00;
    req_addr_i  = '0;

    // A lone requester wins regardless of history.
    txn("solo1", 1, 1'b0, 10'h004, 32'h0, 1'b0, 32'h22222222);

    // Reset during ACCESS of a write drops the transaction.
    req_valid_i = 2'b10;
    req_we_i    = 2'b10;
    req_addr_i[AWIDTH +: AWIDTH]  = 10'h020;
    req_wdata_i[DWIDTH +: DWIDTH] = 32'h55AA55AA;
    #1;
    chk("rst ready", 64'(req_ready_o), 64'b10);
    step();
    req_valid_i = 2'b00;
    req_we_i    = 2'b00;
    chk("rst access en", 64'(mem_en_o), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("postrst rvalid", 64'(rsp_valid_o), 64'd0);
      chk("postrst en",     64'(mem_en_o),    64'd0);
      step();
    end
    txn("after rst", 0, 1'b0, 10'h010, 32'h0, 1'b0, 32'hDEADBEEF);
    txn("rd020",     1, 1'b0, 10'h020, 32'h0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEMSIZE, default 'h400, memory size in bytes.
REQ-002 SHALL have parameter DWIDTH, default 32, data width in bits; BYTESPERW = DWIDTH/8, AWIDTH = $clog2(MEMSIZE) as derived localparams.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid_i  input  2  per-requester request valid; port 0 fetch, port 1 load/store.
REQ-006 SHALL have port req_ready_o  output  2  per-requester grant; accept = valid & ready.
REQ-007 SHALL have port req_we_i  input  2  per-requester write enable.
REQ-008 SHALL have port req_addr_i  input  2*AWIDTH  per-requester byte address, port n at [n*AWIDTH +: AWIDTH].
REQ-009 SHALL have port req_wdata_i  input  2*DWIDTH  per-requester write data, port n at [n*DWIDTH +: DWIDTH].
REQ-010 SHALL have port rsp_valid_o  output  2  one-cycle response pulse to the accepted port.
REQ-011 SHALL have port rsp_err_o  output  1  response error flag, valid with rsp_valid_o.
REQ-012 SHALL have port rsp_rdata_o  output  DWIDTH  registered read data, valid with rsp_valid_o.
REQ-013 SHALL have ports mem_en_o, mem_wen_o (output 1 each), mem_addr_o (output AWIDTH), mem_wdata_o (output DWIDTH) driving the byte-addressed read/write memory.
REQ-014 SHALL have port mem_rdata_i  input  DWIDTH  combinational read data from that memory.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accept, ACCESS->RESP always, RESP->IDLE always.
REQ-016 SHALL assert req_ready_o only in IDLE, to at most one port, and only to a port whose req_valid_i is high (combinational from req_valid_i).
REQ-017 SHALL, on accept, register port id, we, addr, wdata; requester may change or drop its inputs afterwards.
REQ-018 SHALL, in ACCESS, drive mem_en_o=1, mem_wen_o=latched we, mem_addr_o/mem_wdata_o from registers; all mem_* outputs 0 in other states.
REQ-019 SHALL, in ACCESS for a read, capture mem_rdata_i into rsp_rdata_o; for a write, load rsp_rdata_o with 0.
REQ-020 SHALL, in RESP, pulse rsp_valid_o for the latched port only; latency accept-edge to rsp_valid_o = 2 cycles, throughput one transaction per 3 cycles.
REQ-021 SHALL flag out-of-range when latched addr + BYTESPERW - 1 > MEMSIZE - 1: keep mem_en_o=0 in ACCESS, return rsp_err_o=1, rsp_rdata_o=0; memory not modified.
REQ-022 SHALL hold rsp_rdata_o and rsp_err_o stable from RESP until the next ACCESS overwrites them.
REQ-023 SHALL, when exactly one port requests in IDLE, grant that port regardless of arbitration history.
REQ-024 SHALL update last_grant register on every accept to the accepted port id.

Reset
REQ-025 SHALL, while reset_n=0, force FSM to IDLE, last_grant=1, req_ready_o=0 (combinationally from reset state only), rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, all mem_* outputs 0.
REQ-026 SHALL drop any in-flight transaction on reset assertion with no response; a write already sampled by the memory is not undone.

Configuration
REQ-027 SHALL, with macro MEM_ARBITER_RR_EN defined, arbitrate simultaneous requests round-robin: grant the port not equal to last_grant.
REQ-028 SHALL, without MEM_ARBITER_RR_EN, arbitrate simultaneous requests fixed-priority with port 1 winning; last_grant still maintained but unused.

Verification
REQ-029 SHALL cover: port 0 write addr 'h010 data 'hDEADBEEF, then port 0 read 'h010 -> rsp_valid_o=2'b01 two cycles after each accept, read rsp_rdata_o='hDEADBEEF, rsp_err_o=0.
REQ-030 SHALL cover: after reset, both ports hold valid reading 'h000 and 'h004 for 12 cycles with RR_EN -> grants alternate 0,1,0,1; without RR_EN -> port 1 granted every time.
REQ-031 SHALL cover: port 1 read 'h3FD (MEMSIZE='h400, DWIDTH=32) -> mem_en_o never high, rsp_err_o=1, rsp_rdata_o=0; read 'h3FC -> rsp_err_o=0.
REQ-032 SHALL cover: port 1 write 'h020 accepted, reset_n pulled low during ACCESS -> no rsp_valid_o, all outputs 0 immediately, FSM IDLE after release, next request served normally.
REQ-033 SHALL cover: requester changes req_addr_i/req_wdata_i the cycle after accept -> mem_addr_o/mem_wdata_o in ACCESS equal the accepted values; req_ready_o=0 during ACCESS and RESP.
